fp_stream_reducer: RTL and testbench

- Single-precision floating-point sum reducer for one packetised stream. A `last` flag delimits each packet; the block emits one sum per packet.
- Accepts one beat per cycle with no latency stalls. It rotates FP_ADDER_LATENCY partial sums through the pipelined FloPoCo adder, then folds those partials into one result after `last`.
- Sits between the per-node scoring pipes and the result writer.
- Adds backpressure on the output side, IEEE special-value handling and a beat count per packet.

---
 rtl/fp_reduce_pkg.sv | 18 +
 rtl/fp_stream_reducer_if.sv | 23 ++
 rtl/FPAdder_8_23_uid2_l2.sv | 83 ++++++++
 rtl/fp_flopoco_conv.sv | 30 +++
 rtl/fp_stream_reducer.sv | 126 ++++++++++++
 tb/tb_fp_stream_reducer.sv | 199 +++++++++++++++++++
 6 files changed

// File: rtl/fp_reduce_pkg.sv
// Shared encodings and constants for the FloPoCo-based stream sum reducer.
package fp_reduce_pkg;

   localparam logic [1:0] EXN_ZERO   = 2'b00;
   localparam logic [1:0] EXN_NORMAL = 2'b01;
   localparam logic [1:0] EXN_INF    = 2'b10;
   localparam logic [1:0] EXN_NAN    = 2'b11;

   localparam logic [33:0] FLO_ZERO  = 34'h0_0000_0000;
   localparam logic [31:0] IEEE_QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      ACCUM,
      COLLAPSE,
      OUT
   } state_t;

endpackage

// File: rtl/fp_stream_reducer_if.sv
// Operand stream in, packet-sum stream out; slave is the reducer side.
interface fp_stream_reducer_if #(
   parameter int COUNT_WIDTH = 16
);
   logic [31:0]            fp_in;
   logic                   fp_in_valid;
   logic                   fp_in_last;
   logic                   fp_in_ready;
   logic [31:0]            aggreg_out;
   logic [COUNT_WIDTH-1:0] aggreg_count;
   logic                   aggreg_out_valid;
   logic                   aggreg_out_ready;

   modport master (
      output fp_in, fp_in_valid, fp_in_last, aggreg_out_ready,
      input  fp_in_ready, aggreg_out, aggreg_count, aggreg_out_valid
   );

   modport slave (
      input  fp_in, fp_in_valid, fp_in_last, aggreg_out_ready,
      output fp_in_ready, aggreg_out, aggreg_count, aggreg_out_valid
   );
endinterface

// File: rtl/FPAdder_8_23_uid2_l2.sv
// Pipelined FloPoCo-format binary32 adder: round-to-nearest-even, denormals flushed.
module FPAdder_8_23_uid2_l2
   import fp_reduce_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seq_stall,
   input  logic [33:0] X,
   input  logic [33:0] Y,
   output logic [33:0] R
);

   function automatic logic [33:0] fp_add(input logic [33:0] a, input logic [33:0] b);
      logic [33:0] hi, lo;
      logic [26:0] mx, my, my_full, s27;
      logic [27:0] s;
      logic [24:0] m;
      logic        rnd, found;
      int          d, lz, e;
      if (a[33:32] == EXN_NAN || b[33:32] == EXN_NAN) return {EXN_NAN, 32'h0};
      if (a[33:32] == EXN_INF && b[33:32] == EXN_INF)
         return (a[31] == b[31]) ? a : {EXN_NAN, 32'h0};
      if (a[33:32] == EXN_INF) return a;
      if (b[33:32] == EXN_INF) return b;
      if (a[33:32] == EXN_ZERO && b[33:32] == EXN_ZERO)
         return {EXN_ZERO, a[31] & b[31], 31'h0};
      if (a[33:32] == EXN_ZERO) return b;
      if (b[33:32] == EXN_ZERO) return a;
      if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
      else begin hi = b; lo = a; end
      d       = int'(hi[30:23]) - int'(lo[30:23]);
      mx      = {1'b1, hi[22:0], 3'b000};
      my_full = {1'b1, lo[22:0], 3'b000};
      // guard, round and sticky bits below the mantissa
      if (d > 26) my = 27'd1;
      else begin
         my    = my_full >> d;
         my[0] = my[0] | (|(my_full & ((27'd1 << d) - 27'd1)));
      end
      if (hi[31] == lo[31]) s = {1'b0, mx} + {1'b0, my};
      else                  s = {1'b0, mx} - {1'b0, my};
      if (s == 28'h0) return FLO_ZERO;
      e = int'(hi[30:23]);
      if (s[27]) begin
         s27 = s[27:1] | {26'h0, s[0]};
         e   = e + 1;
      end else begin
         lz    = 0;
         found = 1'b0;
         for (int i = 26; i >= 0; i--) begin
            if (s[i]) found = 1'b1;
            else if (!found) lz++;
         end
         s27 = s[26:0] << lz;
         e   = e - lz;
      end
      rnd = s27[2] & (s27[1] | s27[0] | s27[3]);
      m   = {1'b0, s27[26:3]} + {24'h0, rnd};
      if (m[24]) begin
         e = e + 1;
         m = m >> 1;
      end
      if (e >= 255) return {EXN_INF, hi[31], 31'h0};
      if (e <= 0)   return {EXN_ZERO, hi[31], 31'h0};
      return {EXN_NORMAL, hi[31], e[7:0], m[22:0]};
   endfunction

   logic [33:0] pipe [LATENCY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) pipe[i] <= FLO_ZERO;
      end else if (!seq_stall) begin
         pipe[0] <= fp_add(X, Y);
         for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign R = pipe[LATENCY-1];

endmodule

// File: rtl/fp_flopoco_conv.sv
// Combinational IEEE binary32 <-> FloPoCo 34-bit (exn,sign,exp,frac) conversion.
module fp_flopoco_conv
   import fp_reduce_pkg::*;
(
   input  logic [31:0] ieee_in,
   output logic [33:0] flo_out,
   input  logic [33:0] flo_in,
   output logic [31:0] ieee_out
);

   always_comb begin
      if (ieee_in[30:23] == 8'hFF)
         flo_out = {(ieee_in[22:0] == 23'h0) ? EXN_INF : EXN_NAN, ieee_in};
      else if (ieee_in[30:23] == 8'h00)
         flo_out = {EXN_ZERO, ieee_in};
      else
         flo_out = {EXN_NORMAL, ieee_in};
   end

   // -0 collapses to +0 and every NaN to the canonical quiet NaN
   always_comb begin
      case (flo_in[33:32])
         EXN_NORMAL: ieee_out = flo_in[31:0];
         EXN_INF:    ieee_out = {flo_in[31], 31'h7F80_0000};
         EXN_NAN:    ieee_out = IEEE_QNAN;
         default:    ieee_out = 32'h0;
      endcase
   end

endmodule

// File: rtl/fp_stream_reducer.sv
// Per-packet FP sum: beats rotate through L adder slots, then the L partials are folded.
//   state    | meaning
//   ACCUM    | accept beats, each added into the slot emerging from the adder
//   COLLAPSE | pair up live partials through the adder until one remains
//   OUT      | hold sum and beat count until downstream accepts
module fp_stream_reducer
   import fp_reduce_pkg::*;
#(
   parameter int FP_ADDER_LATENCY = 2,
   parameter int COUNT_WIDTH      = 16
) (
   input  logic                clk,
   input  logic                rst,
   fp_stream_reducer_if.slave  bus
);

   localparam int         L         = FP_ADDER_LATENCY;
   localparam logic [3:0] LIVE_INIT = 4'(L);

   state_t                 state;
   logic [L-1:0]           live_pipe;
   logic [33:0]            add_x, add_y, add_r, in_flo, hold;
   logic [31:0]            r_ieee;
   logic                   hold_valid, issue_live, accept, e_live;
   logic [3:0]             live_count;
   logic [COUNT_WIDTH-1:0] beat_cnt;

   assign accept = bus.fp_in_valid & bus.fp_in_ready;
   assign e_live = live_pipe[L-1];

   fp_flopoco_conv u_conv (
      .ieee_in  (bus.fp_in),
      .flo_out  (in_flo),
      .flo_in   (add_r),
      .ieee_out (r_ieee)
   );

   FPAdder_8_23_uid2_l2 #(.LATENCY(L)) u_add (
      .clk       (clk),
      .rst       (rst),
      .seq_stall (1'b0),
      .X         (add_x),
      .Y         (add_y),
      .R         (add_r)
   );

   always_comb begin
      add_x      = FLO_ZERO;
      add_y      = FLO_ZERO;
      issue_live = 1'b0;
      case (state)
         ACCUM: begin
            add_x      = accept ? in_flo : FLO_ZERO;
            add_y      = add_r;
            issue_live = 1'b1;
         end
         COLLAPSE: begin
            if (e_live && hold_valid) begin
               add_x      = hold;
               add_y      = add_r;
               issue_live = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= ACCUM;
         live_pipe            <= '1;
         hold                 <= FLO_ZERO;
         hold_valid           <= 1'b0;
         live_count           <= '0;
         beat_cnt             <= '0;
         bus.fp_in_ready      <= 1'b0;
         bus.aggreg_out       <= 32'h0;
         bus.aggreg_count     <= '0;
         bus.aggreg_out_valid <= 1'b0;
      end else begin
         live_pipe <= L'({live_pipe, issue_live});
         case (state)
            ACCUM: begin
               bus.fp_in_ready <= 1'b1;
               if (accept) begin
                  if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
                  if (bus.fp_in_last) begin
                     state           <= COLLAPSE;
                     bus.fp_in_ready <= 1'b0;
                     live_count      <= LIVE_INIT;
                  end
               end
            end
            COLLAPSE: begin
               // dead tokens carry +0 and are simply let through
               if (e_live) begin
                  if (hold_valid) begin
                     hold_valid <= 1'b0;
                     live_count <= live_count - 4'd1;
                  end else if (live_count == 4'd1) begin
                     bus.aggreg_out       <= r_ieee;
                     bus.aggreg_count     <= beat_cnt;
                     bus.aggreg_out_valid <= 1'b1;
                     state                <= OUT;
                  end else begin
                     hold       <= add_r;
                     hold_valid <= 1'b1;
                  end
               end
            end
            OUT: begin
               // ring already holds only +0 tokens, so re-arming the live bits suffices
               if (bus.aggreg_out_ready) begin
                  bus.aggreg_out_valid <= 1'b0;
                  bus.fp_in_ready      <= 1'b1;
                  live_pipe            <= '1;
                  beat_cnt             <= '0;
                  state                <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_stream_reducer.sv
// Directed bench for fp_stream_reducer: packet sums, backpressure, specials, reset abort.
module tb_fp_stream_reducer;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   fp_stream_reducer_if #(.COUNT_WIDTH(16)) bus  ();
   fp_stream_reducer_if #(.COUNT_WIDTH(16)) bus1 ();
   fp_stream_reducer_if #(.COUNT_WIDTH(16)) bus4 ();

   fp_stream_reducer #(.FP_ADDER_LATENCY(2), .COUNT_WIDTH(16)) dut (
      .clk (clk), .rst (rst), .bus (bus)
   );
   fp_stream_reducer #(.FP_ADDER_LATENCY(1), .COUNT_WIDTH(16)) dut1 (
      .clk (clk), .rst (rst), .bus (bus1)
   );
   fp_stream_reducer #(.FP_ADDER_LATENCY(4), .COUNT_WIDTH(16)) dut4 (
      .clk (clk), .rst (rst), .bus (bus4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // all tasks start and end on a falling edge
   task automatic send(input logic [31:0] d, input logic l);
      int n;
      bus.fp_in       = d;
      bus.fp_in_valid = 1'b1;
      bus.fp_in_last  = l;
      n = 0;
      while (bus.fp_in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("accept", 32'(bus.fp_in_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.fp_in_valid = 1'b0;
      bus.fp_in_last  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (bus.aggreg_out_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(bus.aggreg_out_valid), 32'd1);
   endtask

   task automatic get_result(input logic [31:0] expv, input int cnt, input string tag);
      wait_valid(tag);
      chk({tag, "_data"}, bus.aggreg_out, expv);
      chk({tag, "_count"}, 32'(bus.aggreg_count), 32'(cnt));
      bus.aggreg_out_ready = 1'b1;
      @(negedge clk);
      bus.aggreg_out_ready = 1'b0;
      chk({tag, "_drop"}, 32'(bus.aggreg_out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(bus.fp_in_ready), 32'd1);
   endtask

   initial begin
      int seen, n;
      rst = 1'b1;
      bus.fp_in = '0;  bus.fp_in_valid = 1'b0;  bus.fp_in_last = 1'b0;  bus.aggreg_out_ready = 1'b0;
      bus1.fp_in = '0; bus1.fp_in_valid = 1'b0; bus1.fp_in_last = 1'b0; bus1.aggreg_out_ready = 1'b0;
      bus4.fp_in = '0; bus4.fp_in_valid = 1'b0; bus4.fp_in_last = 1'b0; bus4.aggreg_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out", bus.aggreg_out, 32'h0);
      chk("rst_count", 32'(bus.aggreg_count), 32'd0);
      chk("rst_valid", 32'(bus.aggreg_out_valid), 32'd0);
      chk("rst_ready", 32'(bus.fp_in_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      send(32'h3F80_0000, 1'b0);
      send(32'h4000_0000, 1'b0);
      send(32'h4040_0000, 1'b0);
      send(32'h4080_0000, 1'b1);
      idle(0);
      chk("ready_collapse", 32'(bus.fp_in_ready), 32'd0);
      get_result(32'h4120_0000, 4, "sum4");

      send(32'h40A0_0000, 1'b1);
      idle(0);
      get_result(32'h40A0_0000, 1, "single_l2");

      bus1.fp_in = 32'h40A0_0000; bus1.fp_in_valid = 1'b1; bus1.fp_in_last = 1'b1;
      bus4.fp_in = 32'h40A0_0000; bus4.fp_in_valid = 1'b1; bus4.fp_in_last = 1'b1;
      chk("l1_ready", 32'(bus1.fp_in_ready), 32'd1);
      chk("l4_ready", 32'(bus4.fp_in_ready), 32'd1);
      @(negedge clk);
      bus1.fp_in_valid = 1'b0; bus1.fp_in_last = 1'b0;
      bus4.fp_in_valid = 1'b0; bus4.fp_in_last = 1'b0;
      n = 0;
      while (!(bus1.aggreg_out_valid === 1'b1 && bus4.aggreg_out_valid === 1'b1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("l1_valid", 32'(bus1.aggreg_out_valid), 32'd1);
      chk("l1_data", bus1.aggreg_out, 32'h40A0_0000);
      chk("l1_count", 32'(bus1.aggreg_count), 32'd1);
      chk("l4_valid", 32'(bus4.aggreg_out_valid), 32'd1);
      chk("l4_data", bus4.aggreg_out, 32'h40A0_0000);
      chk("l4_count", 32'(bus4.aggreg_count), 32'd1);
      bus1.aggreg_out_ready = 1'b1; bus4.aggreg_out_ready = 1'b1;
      @(negedge clk);
      bus1.aggreg_out_ready = 1'b0; bus4.aggreg_out_ready = 1'b0;
      chk("l1_drop", 32'(bus1.aggreg_out_valid), 32'd0);
      chk("l4_drop", 32'(bus4.aggreg_out_valid), 32'd0);

      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) == 1) idle(1);
         chk("gap_ready", 32'(bus.fp_in_ready), 32'd1);
         send(32'h3F80_0000, i == 7);
      end
      idle(0);
      get_result(32'h4100_0000, 8, "gaps8");

      send(32'h3F80_0000, 1'b0);
      send(32'h4000_0000, 1'b1);
      idle(0);
      wait_valid("hold");
      bus.fp_in = 32'h4000_0000; bus.fp_in_valid = 1'b1; bus.fp_in_last = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("hold_data", bus.aggreg_out, 32'h4040_0000);
         chk("hold_count", 32'(bus.aggreg_count), 32'd2);
         chk("hold_valid", 32'(bus.aggreg_out_valid), 32'd1);
         chk("hold_ready", 32'(bus.fp_in_ready), 32'd0);
         @(negedge clk);
      end
      bus.aggreg_out_ready = 1'b1;
      @(negedge clk);
      bus.aggreg_out_ready = 1'b0;
      chk("hold_drop", 32'(bus.aggreg_out_valid), 32'd0);
      send(32'h4000_0000, 1'b0);
      send(32'h4000_0000, 1'b1);
      idle(0);
      get_result(32'h4080_0000, 2, "after_hold");

      send(32'h3F80_0000, 1'b0);
      send(32'h3F80_0000, 1'b1);
      idle(0);
      rst = 1'b1;
      #1;
      chk("abort_out", bus.aggreg_out, 32'h0);
      chk("abort_count", 32'(bus.aggreg_count), 32'd0);
      chk("abort_valid", 32'(bus.aggreg_out_valid), 32'd0);
      chk("abort_ready", 32'(bus.fp_in_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.aggreg_out_valid !== 1'b0) seen++;
      end
      chk("abort_no_pulse", 32'(seen), 32'd0);
      send(32'h4040_0000, 1'b0);
      send(32'h4040_0000, 1'b1);
      idle(0);
      get_result(32'h40C0_0000, 2, "post_reset");

      send(32'h3F80_0000, 1'b0);
      send(32'hBF80_0000, 1'b1);
      idle(0);
      get_result(32'h0000_0000, 2, "p1_m1");
      send(32'h8000_0000, 1'b1);
      idle(0);
      get_result(32'h0000_0000, 1, "neg_zero");
      send(32'h7F80_0000, 1'b0);
      send(32'h3F80_0000, 1'b1);
      idle(0);
      get_result(32'h7F80_0000, 2, "inf_plus_one");
      send(32'h7F80_0000, 1'b0);
      send(32'hFF80_0000, 1'b1);
      idle(0);
      get_result(32'h7FC0_0000, 2, "inf_minus_inf");
      send(32'h0000_0001, 1'b1);
      idle(0);
      get_result(32'h0000_0000, 1, "denormal");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
